// File: rtl/athena_hiscore_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | athena_hiscore_reader                                                    |
// | Answers bridge reads in the hiscore window by fetching bytes from CPU    |
// | work RAM and packing them big-endian.                                    |
// | Option: ATHENA_HISCORE_PIPELINE_EN (back-to-back RAM requests).          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module athena_hiscore_reader #(
   parameter logic [31:0] START_ADDR = 32'h1000fe50,
   parameter logic [31:0] SIZE       = 32'h72
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        rd_req,
   input  logic [31:0] rd_addr,
   output logic [31:0] rd_data,
   output logic        rd_done,
   output logic        busy,
   output logic        ram_req,
   output logic [15:0] ram_addr,
   input  logic        ram_grant,
   input  logic [7:0]  ram_rdata
);

`ifdef ATHENA_HISCORE_PIPELINE_EN
   localparam bit PIPELINE = 1'b1;
`else
   localparam bit PIPELINE = 1'b0;
`endif

   localparam logic [31:0] LAST_ADDR = START_ADDR + SIZE - 32'd1;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_REQ  = 3'd1,
      ST_CAP  = 3'd2,
      ST_SKIP = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [29:0] word_q;
   logic [1:0]  idx_q, idx_d;
   logic        accept_q;
   logic [1:0]  cap_idx_q;
   logic [31:0] data_q;

   logic        accept;
   logic [1:0]  next_idx;
   state_t      next_step;
   logic        unused_addr_bits;

   function automatic logic byte_hit(input logic [29:0] word, input logic [1:0] n);
      logic [31:0] a;
      a = {word, n};
      return (a >= START_ADDR) && (a <= LAST_ADDR);
   endfunction

   function automatic logic word_hit(input logic [29:0] word);
      return byte_hit(word, 2'd0) || byte_hit(word, 2'd1) ||
             byte_hit(word, 2'd2) || byte_hit(word, 2'd3);
   endfunction

   assign unused_addr_bits = ^rd_addr[1:0];

   assign ram_req   = (state_q == ST_REQ);
   assign accept    = ram_req & ram_grant;
   assign ram_addr  = ram_req ? {word_q[13:0], idx_q} : 16'h0000;
   assign rd_done   = (state_q == ST_DONE);
   assign busy      = (state_q != ST_IDLE);
   assign rd_data   = data_q;

   assign next_idx  = idx_q + 2'd1;
   assign next_step = byte_hit(word_q, next_idx) ? ST_REQ : ST_SKIP;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         ST_IDLE: begin
            if (rd_req) begin
               idx_d = 2'd0;
               if (!word_hit(rd_addr[31:2]))
                  state_d = ST_DONE;
               else if (byte_hit(rd_addr[31:2], 2'd0))
                  state_d = ST_REQ;
               else
                  state_d = ST_SKIP;
            end
         end
         ST_REQ: begin
            // In pipelined builds the next request slot follows the grant directly.
            if (ram_grant) begin
               if (!PIPELINE || idx_q == 2'd3) begin
                  state_d = ST_CAP;
               end else begin
                  idx_d   = next_idx;
                  state_d = next_step;
               end
            end
         end
         ST_CAP: begin
            if (PIPELINE || idx_q == 2'd3) begin
               state_d = ST_DONE;
            end else begin
               idx_d   = next_idx;
               state_d = next_step;
            end
         end
         ST_SKIP: begin
            if (idx_q == 2'd3) begin
               state_d = PIPELINE ? ST_CAP : ST_DONE;
            end else begin
               idx_d   = next_idx;
               state_d = next_step;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         word_q    <= '0;
         idx_q     <= '0;
         accept_q  <= 1'b0;
         cap_idx_q <= '0;
         data_q    <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         accept_q <= accept;
         if (accept)
            cap_idx_q <= idx_q;
         if (state_q == ST_IDLE && rd_req) begin
            word_q <= rd_addr[31:2];
            data_q <= '0;
         end
         // Lane n holds byte n, lowest address in the MSB.
         for (int l = 0; l < 4; l++) begin
            if (state_q == ST_SKIP && idx_q == 2'(l))
               data_q[31-8*l -: 8] <= 8'h00;
            if (accept_q && cap_idx_q == 2'(l))
               data_q[31-8*l -: 8] <= ram_rdata;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_athena_hiscore_reader.sv
`default_nettype none
// tb_athena_hiscore_reader: vector table, directed corner sequences and randomized
// reads compared against a byte-window model of the hiscore region.
module tb_athena_hiscore_reader;

   localparam logic [31:0] START = 32'h1000fe50;
   localparam logic [31:0] SIZE  = 32'h72;
`ifdef ATHENA_HISCORE_PIPELINE_EN
   localparam bit PIPE = 1'b1;
`else
   localparam bit PIPE = 1'b0;
`endif

   logic        clk       = 1'b0;
   logic        reset_n   = 1'b0;
   logic        rd_req    = 1'b0;
   logic [31:0] rd_addr   = '0;
   logic        ram_grant = 1'b1;
   logic [7:0]  ram_rdata = '0;
   logic [31:0] rd_data;
   logic        rd_done;
   logic        busy;
   logic        ram_req;
   logic [15:0] ram_addr;

   athena_hiscore_reader dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .rd_req    (rd_req),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .rd_done   (rd_done),
      .busy      (busy),
      .ram_req   (ram_req),
      .ram_addr  (ram_addr),
      .ram_grant (ram_grant),
      .ram_rdata (ram_rdata)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   bit          rand_grant = 1'b0;
   int          stalls = 0;
   bit          req_seen = 1'b0;
   logic [15:0] acc_log[$];
   bit          pend = 1'b0;
   logic [15:0] pend_addr = '0;
   bit          wait_prev = 1'b0;
   logic [15:0] wait_addr = '0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          lat_serial;
      int          lat_pipe;
      int          nacc;
   } vec_t;
   vec_t vt[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] ram_byte(input logic [15:0] a);
      return a[7:0] ^ 8'hA5;
   endfunction

   function automatic bit in_win(input logic [31:0] b);
      return (b >= START) && (b < START + SIZE);
   endfunction

   function automatic logic [31:0] model_word(input logic [31:0] a);
      logic [31:0] w;
      logic [31:0] b;
      w = '0;
      for (int n = 0; n < 4; n++) begin
         b = {a[31:2], 2'(n)};
         if (in_win(b)) w[31-8*n -: 8] = ram_byte(b[15:0]);
      end
      return w;
   endfunction

   function automatic int model_nin(input logic [31:0] a);
      int k;
      k = 0;
      for (int n = 0; n < 4; n++)
         if (in_win({a[31:2], 2'(n)})) k++;
      return k;
   endfunction

   // Base latency with no stalls: serial = 2 cycles per fetched byte, 1 per skipped one.
   function automatic int model_lat(input logic [31:0] a);
      int k;
      k = model_nin(a);
      if (k == 0) return 1;
      return PIPE ? 6 : 1 + 2*k + (4 - k);
   endfunction

   // RAM/arbiter responder: all decisions taken mid-cycle.
   initial begin
      forever begin
         @(negedge clk);
         ram_rdata = pend ? ram_byte(pend_addr) : 8'($urandom);
         if (wait_prev && reset_n) begin
            chk("wait_req_held", 32'(ram_req), 32'd1);
            chk("wait_addr_stable", 32'(ram_addr), 32'(wait_addr));
         end
         ram_grant = rand_grant ? 1'($urandom_range(0, 1)) : 1'b1;
         pend      = ram_req && ram_grant;
         pend_addr = ram_addr;
         if (pend) acc_log.push_back(ram_addr);
         if (ram_req) req_seen = 1'b1;
         wait_prev = ram_req && !ram_grant;
         wait_addr = ram_addr;
         if (wait_prev) stalls++;
         if (rd_done) chk("done_excl_req", 32'(ram_req), 32'd0);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   task automatic do_read(input logic [31:0] a, output int lat, output logic [31:0] d);
      @(negedge clk);
      #2;
      acc_log.delete();
      stalls   = 0;
      req_seen = 1'b0;
      rd_addr  = a;
      rd_req   = 1'b1;
      @(posedge clk);
      #1;
      rd_req = 1'b0;
      lat = 1;
      while (!rd_done && lat < 300) begin
         @(posedge clk);
         #1;
         lat++;
      end
      d = rd_data;
   endtask

   task automatic run_check(input string tag, input logic [31:0] a,
                            input logic [31:0] exp_d, input int exp_lat);
      int          lat;
      logic [31:0] d;
      logic [15:0] exp_acc[$];
      logic [31:0] b;
      do_read(a, lat, d);
      chk({tag, "_data"}, d, exp_d);
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat + stalls));
      for (int n = 0; n < 4; n++) begin
         b = {a[31:2], 2'(n)};
         if (in_win(b)) exp_acc.push_back(b[15:0]);
      end
      chk({tag, "_nacc"}, 32'(acc_log.size()), 32'(exp_acc.size()));
      if (acc_log.size() == exp_acc.size())
         foreach (exp_acc[i]) chk({tag, "_acc_addr"}, 32'(acc_log[i]), 32'(exp_acc[i]));
      @(posedge clk);
      #1;
      chk({tag, "_idle_after"}, 32'(busy), 32'd0);
      chk({tag, "_data_held"}, rd_data, d);
   endtask

   initial begin
      int          ndone;
      int          lat;
      logic [31:0] d;
      logic [31:0] a;

      vt[0] = '{32'h1000fe50, 32'hF5F4F7F6, 9, 6, 4};
      vt[1] = '{32'h1000fec0, 32'h65640000, 7, 6, 2};
      vt[2] = '{32'h10000000, 32'h00000000, 1, 1, 0};
      vt[3] = '{32'h1000fe4c, 32'h00000000, 1, 1, 0};
      vt[4] = '{32'h1000fec4, 32'h00000000, 1, 1, 0};
      vt[5] = '{32'h1000fe53, 32'hF5F4F7F6, 9, 6, 4};
      vt[6] = '{32'h1000fe60, 32'hC5C4C7C6, 9, 6, 4};
      vt[7] = '{32'h1000febc, 32'h19181B1A, 9, 6, 4};
      vt[8] = '{32'h2000fe50, 32'h00000000, 1, 1, 0};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_rd_data", rd_data, 32'd0);
      chk("rst_rd_done", 32'(rd_done), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ram_req", 32'(ram_req), 32'd0);
      chk("rst_ram_addr", 32'(ram_addr), 32'd0);
      @(negedge clk);
      #2;
      reset_n = 1'b1;

      foreach (vt[i]) begin
         run_check("vec", vt[i].addr, vt[i].data, PIPE ? vt[i].lat_pipe : vt[i].lat_serial);
         chk("vec_nacc_table", 32'(acc_log.size()), 32'(vt[i].nacc));
         chk("vec_req_seen", 32'(req_seen), 32'(vt[i].nacc != 0));
         if (vt[i].addr == 32'h1000fec0 && acc_log.size() == 2) begin
            chk("last_acc0", 32'(acc_log[0]), 32'h0000fec0);
            chk("last_acc1", 32'(acc_log[1]), 32'h0000fec1);
         end
      end

      // A second strobe while busy must be dropped.
      @(negedge clk);
      #2;
      acc_log.delete();
      rd_addr = START + 32'h10;
      rd_req  = 1'b1;
      @(posedge clk);
      #1;
      rd_req = 1'b0;
      ndone = 0;
      lat   = 0;
      d     = '0;
      for (int k = 1; k <= 20; k++) begin
         if (rd_done) begin
            ndone++;
            lat = k;
            d   = rd_data;
         end
         if (k == 3) begin
            rd_addr = START;
            rd_req  = 1'b1;
         end
         if (k == 4) rd_req = 1'b0;
         @(posedge clk);
         #1;
      end
      chk("busy_drop_ndone", 32'(ndone), 32'd1);
      chk("busy_drop_lat", 32'(lat), PIPE ? 32'd6 : 32'd9);
      chk("busy_drop_data", d, 32'hC5C4C7C6);
      chk("busy_drop_nacc", 32'(acc_log.size()), 32'd4);

      // Asynchronous reset in the middle of a read.
      @(negedge clk);
      #2;
      rd_addr = START;
      rd_req  = 1'b1;
      @(posedge clk);
      #1;
      rd_req = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("pre_rst_busy", 32'(busy), 32'd1);
      @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      chk("mid_rst_rd_data", rd_data, 32'd0);
      chk("mid_rst_rd_done", 32'(rd_done), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_ram_req", 32'(ram_req), 32'd0);
      chk("mid_rst_ram_addr", 32'(ram_addr), 32'd0);
      @(negedge clk);
      #2;
      reset_n = 1'b1;
      run_check("post_rst", START + 32'h4, model_word(START + 32'h4), model_lat(START + 32'h4));

      for (int i = 0; i < 30; i++) begin
         rand_grant = (i % 3 != 0);
         a = START - 32'd8 + 32'(4 * $urandom_range(0, 32));
         a = a | 32'($urandom_range(0, 3));
         run_check("rand", a, model_word(a), model_lat(a));
      end
      rand_grant = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/athena_hiscore_reader.md
# athena_hiscore_reader

Bridge-read responder for the Athena hiscore slot. It answers 32-bit Pocket bridge reads in the hiscore window (slot 2, load base 0x1000fe50, 0x72 bytes), which is the save direction. It fetches each byte from the CPU-side work RAM through an arbitrated byte port, then packs the bytes big-endian into one bridge word. It sits between the bridge read mux and the CPU RAM arbiter, in the core clock domain.

## Interface
- `START_ADDR`, 32'h1000fe50: bridge byte address of hiscore byte 0; bits [15:0] equal the CPU address.
- `SIZE`, 32'h72: hiscore length in bytes.
- `clk` in 1: core clock, the only clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `rd_req` in 1: one-cycle read strobe; sampled only while `busy`=0.
- `rd_addr` in 32: bridge byte address; bits [1:0] ignored.
- `rd_data` out 32: assembled word; valid when `rd_done`=1, held until the next accepted `rd_req`.
- `rd_done` out 1: one-cycle completion pulse.
- `busy` out 1: high from the cycle after an accepted `rd_req` through the `rd_done` cycle.
- `ram_req` out 1: byte-read request to the arbiter.
- `ram_addr` out 16: CPU byte address, {word[15:2], byte index}.
- `ram_grant` in 1: the arbiter accepts the request in any cycle where `ram_req`&`ram_grant`.
- `ram_rdata` in 8: valid exactly one cycle after an accepting cycle.

## Operation
- Reset values: `rd_data`=0, `rd_done`=0, `busy`=0, `ram_req`=0, `ram_addr`=0; FSM is IDLE.
- States: IDLE, REQ, CAP, SKIP, DONE.
- IDLE: `rd_req` latches the word address and sets the byte index to 0.
  - If the whole word lies outside [START_ADDR, START_ADDR+SIZE-1], go to DONE with data 0 and no RAM access.
  - Otherwise go to REQ.
- Byte index n maps to CPU address `rd_addr[15:2]`,n.
- Byte n lands in `rd_data[31-8n -: 8]`, so the lowest address is the MSB, per the bridge convention.
- REQ: drive `ram_req`=1 with the byte address.
  - Without grant: hold `ram_req` and `ram_addr` stable and stay in REQ.
  - With grant: go to CAP.
- CAP: capture `ram_rdata` into lane n, then move to the next byte.
- Out-of-range bytes (address > START_ADDR+SIZE-1, or < START_ADDR): go through SKIP. SKIP takes one cycle, loads 0x00 into the lane and never asserts `ram_req`.
- After byte 3: go to DONE, which pulses `rd_done` for one cycle and then returns to IDLE.
- `rd_req` while `busy`=1 is dropped: no queueing, no error.
- Capture is keyed to a registered accept flag (`ram_req`&`ram_grant` delayed one cycle), never to FSM state alone.
- Mid-operation `reset_n` low: everything returns to reset values immediately. A pending arbiter transaction is abandoned; the arbiter is responsible for tolerating this.

## Timing
- Cycle 0 is the `rd_req` sample cycle.
- Full in-range word, `ram_grant` tied high, macro off: accepts in cycles 1/3/5/7, captures in 2/4/6/8, `rd_done` in cycle 9.
- Each cycle of `ram_grant`=0 during REQ adds exactly one cycle.
- Word fully out of range: `rd_done` in cycle 1, `rd_data`=0.
- Last word 0x1000fec0 (bytes c0,c1 valid), macro off: `rd_done` in cycle 7.
- `rd_done` is never asserted in the same cycle as `ram_req`.

## Configuration
- `ATHENA_HISCORE_PIPELINE_EN` defined: back-to-back requests.
  - The request for byte n+1 is issued in the same cycle byte n is captured.
  - `ram_req` stays high across bytes while granted; a skipped byte uses its request slot with `ram_req`=0.
  - Full word with grant tied high: accepts in cycles 1–4, captures in 2–5, `rd_done` in cycle 6. The last word also completes in cycle 6.
- Undefined: the serial REQ/CAP behaviour above.
- Port list and data results are identical in both builds.

## Test plan
- RAM model returning addr[7:0]^0xA5, grant high, read 0x1000fe50 → `rd_data`=0xF5F4F7F6, `rd_done` in cycle 9 (cycle 6 with macro).
- Read 0x1000fec0 → `rd_data`=0x6564_0000; only two accepts seen, CPU addresses 0xfec0 and 0xfec1.
- Read 0x10000000 → `rd_data`=0, `rd_done` in cycle 1, `ram_req` never asserted.
- Random `ram_grant` with 50% duty → `ram_addr` stable while waiting; data matches the model; latency equals the base count plus the number of stall cycles.
- Second `rd_req` in cycle 3 → ignored; exactly one `rd_done`.
- `reset_n` low in cycle 4 → all outputs 0 asynchronously. A new read after release completes correctly.
